// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, write-back port, hazard stalls and the ID/EX register outputs.
// No valid/ready handshake here: every signal is sampled or produced once per clock; StallF/StallD are the only back-pressure.
interface decode_cycle_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] InstrD;
    logic [DATA_W-1:0] PCD;
    logic [DATA_W-1:0] PCPlus4D;
    logic              FlushE;
    logic              RegWriteW;
    logic [ADDR_W-1:0] RdW;
    logic [DATA_W-1:0] ResultW;

    logic              StallF;
    logic              StallD;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              MemReadE;
    logic              BranchE;
    logic              JumpE;
    logic              ALUSrcE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] ImmExtE;
    logic [DATA_W-1:0] PCE;
    logic [DATA_W-1:0] PCPlus4E;
    logic [ADDR_W-1:0] RdE;
    logic [ADDR_W-1:0] Rs1E;
    logic [ADDR_W-1:0] Rs2E;
    logic              IllegalE;

    // master: fetch / write-back / execute side that drives decode.
    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        input  StallF, StallD, RegWriteE, MemWriteE, MemReadE, BranchE, JumpE,
               ALUSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RdE, Rs1E, Rs2E, IllegalE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        output StallF, StallD, RegWriteE, MemWriteE, MemReadE, BranchE, JumpE,
               ALUSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RdE, Rs1E, Rs2E, IllegalE
    );
endinterface

// File: rtl/decode_cycle.sv
// Decode stage of the 20-bit core: decode, register file, load-use hazard, ID/EX register.
// Optional macro DECODE_ILLEGAL_TRAP_EN raises IllegalE for illegal opcodes; otherwise IllegalE is 0.
module decode_cycle #(
    parameter int DATA_W    = 20,
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = 4
) (
    input logic           clk,
    input logic           rst,
    decode_cycle_if.slave bus
);

    typedef struct packed {
        logic              regWrite;
        logic              memWrite;
        logic              memRead;
        logic              branch;
        logic              jump;
        logic              aluSrc;
        logic              illegal;
        logic [2:0]        aluControl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] immExt;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pcPlus4;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
    } eStage_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_JAL  = 4'd9;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    logic [3:0]        op;
    logic [ADDR_W-1:0] rdF;
    logic [ADDR_W-1:0] rs1F;
    logic [ADDR_W-1:0] rs2F;
    logic [DATA_W-1:0] imm8Ext;
    logic [DATA_W-1:0] imm12Ext;

    assign op       = bus.InstrD[19:16];
    assign rdF      = bus.InstrD[15:12];
    assign rs1F     = bus.InstrD[11:8];
    assign rs2F     = bus.InstrD[7:4];
    assign imm8Ext  = {{(DATA_W-8){bus.InstrD[7]}}, bus.InstrD[7:0]};
    assign imm12Ext = {{(DATA_W-12){bus.InstrD[11]}}, bus.InstrD[11:0]};

    // Control decode. Unused read ports are addressed at r0 so they read 0
    // and can never match a load destination in the hazard compare.
    eStage_t           ctrl;
    logic [ADDR_W-1:0] rs1Addr;
    logic [ADDR_W-1:0] rs2Addr;

    always_comb begin
        ctrl    = '0;
        rs1Addr = '0;
        rs2Addr = '0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                ctrl.regWrite = 1'b1;
                ctrl.rd       = rdF;
                rs1Addr       = rs1F;
                rs2Addr       = rs2F;
                case (op)
                    OP_SUB:  ctrl.aluControl = ALU_SUB;
                    OP_AND:  ctrl.aluControl = ALU_AND;
                    OP_OR:   ctrl.aluControl = ALU_OR;
                    default: ctrl.aluControl = ALU_ADD;
                endcase
            end
            OP_ADDI: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.rd       = rdF;
                ctrl.immExt   = imm8Ext;
                rs1Addr       = rs1F;
            end
            OP_LW: begin
                ctrl.regWrite = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.rd       = rdF;
                ctrl.immExt   = imm8Ext;
                rs1Addr       = rs1F;
            end
            OP_SW: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.immExt   = imm8Ext;
                rs1Addr       = rs1F;
                rs2Addr       = rdF;
            end
            OP_BEQ: begin
                ctrl.branch     = 1'b1;
                ctrl.aluControl = ALU_SUB;
                ctrl.immExt     = imm8Ext << 2;
                rs1Addr         = rs1F;
                rs2Addr         = rdF;
            end
            OP_JAL: begin
                ctrl.regWrite = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.rd       = rdF;
                ctrl.immExt   = imm12Ext << 2;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                ctrl.illegal = 1'b1;
`else
                ctrl.illegal = 1'b0;
`endif
            end
        endcase
    end

    // Register file: contents survive reset; write-back bypasses same-cycle reads.
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wbActive;

    assign wbActive = bus.RegWriteW && (bus.RdW != '0);

    always_ff @(posedge clk) begin
        if (wbActive) begin
            regs[bus.RdW] <= bus.ResultW;
        end
    end

    always_comb begin
        rd1 = '0;
        if (rs1Addr != '0) begin
            rd1 = (wbActive && bus.RdW == rs1Addr) ? bus.ResultW : regs[rs1Addr];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rs2Addr != '0) begin
            rd2 = (wbActive && bus.RdW == rs2Addr) ? bus.ResultW : regs[rs2Addr];
        end
    end

    eStage_t eReg;
    eStage_t nextE;
    logic    hazard;

    always_comb begin
        nextE         = ctrl;
        nextE.rd1     = rd1;
        nextE.rd2     = rd2;
        nextE.pc      = bus.PCD;
        nextE.pcPlus4 = bus.PCPlus4D;
        nextE.rs1     = rs1Addr;
        nextE.rs2     = rs2Addr;
    end

    // A flush already discards the dependent instruction, so no stall is needed.
    assign hazard = eReg.memRead && (eReg.rd != '0) && !bus.FlushE &&
                    ((eReg.rd == rs1Addr) || (eReg.rd == rs2Addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            eReg <= '0;
        end else if (bus.FlushE) begin
            eReg <= '0;
        end else if (hazard) begin
            eReg <= '0;
        end else begin
            eReg <= nextE;
        end
    end

    assign bus.StallF      = hazard;
    assign bus.StallD      = hazard;
    assign bus.RegWriteE   = eReg.regWrite;
    assign bus.MemWriteE   = eReg.memWrite;
    assign bus.MemReadE    = eReg.memRead;
    assign bus.BranchE     = eReg.branch;
    assign bus.JumpE       = eReg.jump;
    assign bus.ALUSrcE     = eReg.aluSrc;
    assign bus.ALUControlE = eReg.aluControl;
    assign bus.RD1E        = eReg.rd1;
    assign bus.RD2E        = eReg.rd2;
    assign bus.ImmExtE     = eReg.immExt;
    assign bus.PCE         = eReg.pc;
    assign bus.PCPlus4E    = eReg.pcPlus4;
    assign bus.RdE         = eReg.rd;
    assign bus.Rs1E        = eReg.rs1;
    assign bus.Rs2E        = eReg.rs2;
    assign bus.IllegalE    = eReg.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed self-checking bench for decode_cycle: reset, bypass, load-use stall, flush, immediates, illegal opcodes.
// Expectations for IllegalE follow DECODE_ILLEGAL_TRAP_EN.
module tb_decode_cycle;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [2:0] exp_q[$];

    decode_cycle_if #(.DATA_W(20), .ADDR_W(4)) bus ();

    decode_cycle #(.DATA_W(20), .REG_COUNT(16), .ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [121:0] eAll;
    assign eAll = {bus.RegWriteE, bus.MemWriteE, bus.MemReadE, bus.BranchE, bus.JumpE,
                   bus.ALUSrcE, bus.IllegalE, bus.ALUControlE, bus.RD1E, bus.RD2E,
                   bus.ImmExtE, bus.PCE, bus.PCPlus4E, bus.RdE, bus.Rs1E, bus.Rs2E};

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EXP = 1'b1;
`else
    localparam logic TRAP_EXP = 1'b0;
`endif

    function automatic logic [19:0] enc(input int op, input int rd, input int rs1, input int lo8);
        logic [19:0] w;
        w = {op[3:0], rd[3:0], rs1[3:0], lo8[7:0]};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_wb(input logic we, input logic [3:0] rd, input logic [19:0] data);
        bus.RegWriteW = we;
        bus.RdW       = rd;
        bus.ResultW   = data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst          = 1'b1;
        bus.InstrD   = enc(1, 1, 2, 8'h30);
        bus.PCD      = 20'h00200;
        bus.PCPlus4D = 20'h00204;
        bus.FlushE   = 1'b0;
        drive_wb(1'b0, 4'd0, 20'h0);

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_e_zero", eAll, '0);
            chk("reset_stallf", bus.StallF, 0);
            chk("reset_stalld", bus.StallD, 0);
        end

        rst = 1'b0;
        step();
        chk("add_regwrite", bus.RegWriteE, 1);
        chk("add_aluctl", bus.ALUControlE, 3'b000);
        chk("add_rs1", bus.Rs1E, 2);
        chk("add_rs2", bus.Rs2E, 3);
        chk("add_rd", bus.RdE, 1);
        chk("add_alusrc", bus.ALUSrcE, 0);
        chk("add_pc", bus.PCE, 20'h00200);
        chk("add_pc4", bus.PCPlus4E, 20'h00204);

        // Write r5 while ADDI r6,r5,0xFF reads it in the same cycle
        drive_wb(1'b1, 4'd5, 20'h0ABCD);
        bus.InstrD = enc(5, 6, 5, 8'hFF);
        step();
        chk("addi_bypass_rd1", bus.RD1E, 20'h0ABCD);
        chk("addi_imm", bus.ImmExtE, 20'hFFFFF);
        chk("addi_alusrc", bus.ALUSrcE, 1);
        chk("addi_rd", bus.RdE, 6);
        chk("addi_rs2", bus.Rs2E, 0);

        drive_wb(1'b0, 4'd0, 20'h0);
        bus.InstrD = enc(1, 7, 5, 8'h00);
        step();
        chk("r5_stored", bus.RD1E, 20'h0ABCD);
        chk("r0_port2", bus.RD2E, 0);

        // Write to r0 must be dropped, including the bypass path
        drive_wb(1'b1, 4'd0, 20'h12345);
        bus.InstrD = enc(1, 8, 0, 8'h00);
        step();
        chk("r0_bypass", bus.RD1E, 0);
        drive_wb(1'b0, 4'd0, 20'h0);
        bus.InstrD = enc(1, 8, 0, 8'h50);
        step();
        chk("r0_read", bus.RD1E, 0);
        chk("r5_port2", bus.RD2E, 20'h0ABCD);

        // R-type ALU control table through the expected queue
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(3'(k - 1));
            bus.InstrD = enc(k, 2, 3, 8'h40);
            step();
            chk("rtype_aluctl", bus.ALUControlE, exp_q.pop_front());
        end

        // Load-use: LW r4,0(r1) then ADD r7,r4,r2
        bus.InstrD = enc(6, 4, 1, 8'h00);
        step();
        chk("lw_memread", bus.MemReadE, 1);
        chk("lw_rd", bus.RdE, 4);
        bus.InstrD = enc(1, 7, 4, 8'h20);
        #1;
        chk("lu_stallf", bus.StallF, 1);
        chk("lu_stalld", bus.StallD, 1);
        step();
        chk("lu_bubble", eAll, '0);
        chk("lu_stall_clear", bus.StallF, 0);
        step();
        chk("lu_add_regwrite", bus.RegWriteE, 1);
        chk("lu_add_rs1", bus.Rs1E, 4);
        chk("lu_add_rs2", bus.Rs2E, 2);
        chk("lu_add_stall", bus.StallD, 0);

        // Load-use with a flush in the hazard cycle
        bus.InstrD = enc(6, 4, 1, 8'h00);
        step();
        bus.InstrD = enc(1, 7, 4, 8'h20);
        bus.FlushE = 1'b1;
        #1;
        chk("flush_stallf", bus.StallF, 0);
        chk("flush_stalld", bus.StallD, 0);
        step();
        chk("flush_bubble", eAll, '0);
        bus.FlushE = 1'b0;
        step();
        chk("post_flush_add", bus.RegWriteE, 1);

        // BEQ r3,r3 with negative offset
        bus.InstrD = enc(8, 3, 3, 8'h80);
        step();
        chk("beq_branch", bus.BranchE, 1);
        chk("beq_imm", bus.ImmExtE, 20'hFFE00);
        chk("beq_regwrite", bus.RegWriteE, 0);
        chk("beq_aluctl", bus.ALUControlE, 3'b001);
        chk("beq_rs2", bus.Rs2E, 3);

        // SW r9 -> 4(r1): port 2 addressed by [15:12]
        bus.InstrD = enc(7, 9, 1, 8'h04);
        step();
        chk("sw_memwrite", bus.MemWriteE, 1);
        chk("sw_rs2", bus.Rs2E, 9);
        chk("sw_rs1", bus.Rs1E, 1);
        chk("sw_rd", bus.RdE, 0);
        chk("sw_imm", bus.ImmExtE, 20'h00004);

        // JAL r1, imm12=0x004
        bus.InstrD   = {4'd9, 4'd1, 12'h004};
        bus.PCD      = 20'h00100;
        bus.PCPlus4D = 20'h00104;
        step();
        chk("jal_jump", bus.JumpE, 1);
        chk("jal_regwrite", bus.RegWriteE, 1);
        chk("jal_imm", bus.ImmExtE, 20'h00010);
        chk("jal_pc4", bus.PCPlus4E, 20'h00104);
        chk("jal_rd", bus.RdE, 1);

        // Illegal opcode: flushed copy first, then a live one
        bus.InstrD = 20'hF0000;
        bus.FlushE = 1'b1;
        step();
        chk("illegal_flushed", bus.IllegalE, 0);
        bus.FlushE = 1'b0;
        step();
        chk("illegal_flag", bus.IllegalE, TRAP_EXP);
        chk("illegal_regwrite", bus.RegWriteE, 0);
        chk("illegal_memread", bus.MemReadE, 0);
        chk("illegal_aluctl", bus.ALUControlE, 0);
        bus.InstrD = 20'h00000;
        step();
        chk("illegal_one_cycle", bus.IllegalE, 0);

        // Reset mid-stream clears a pending load
        bus.InstrD = enc(6, 4, 1, 8'h00);
        step();
        rst = 1'b1;
        step();
        chk("midreset_e_zero", eAll, '0);
        chk("midreset_stall", bus.StallF, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
